vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing generator at the head of the VGA pixel pipeline.
//  - Runs horizontal/vertical counters on vga_clk.
//  - Issues lookahead pixel requests (pos_x/pos_y) to the registered pixel stages
//    (text panels, keyboard graphics).
//  - Captures their returned pix_data.
//  - Drives hsync/vsync/de/rgb to the DAC pins, all mutually aligned.
// PARAMETERS
//  H_SYNC   96   hsync pulse width, pixels
//  H_BACK   48   horizontal back porch, pixels
//  H_VALID  640  active pixels per line
//  H_FRONT  16   horizontal front porch, pixels
//  V_SYNC   2    vsync pulse width, lines
//  V_BACK   33   vertical back porch, lines
//  V_VALID  480  active lines per frame
//  V_FRONT  10   vertical front porch, lines
//  LATENCY  1    pixel-stage latency, cycles, pos_* -> pix_data; legal 1..4, <= H_BACK
// PORTS
//  vga_clk     in   1   pixel clock (25.175 MHz nominal)
//  rst_n       in   1   asynchronous, active-low reset
//  pix_data    in   24  RGB888 from pixel stage, LATENCY cycles after the request
//  pos_x       out  10  requested pixel column, 0..H_VALID-1
//  pos_y       out  10  requested pixel row, 0..V_VALID-1
//  pos_valid   out  1   pos_x/pos_y name a real active pixel
//  hsync       out  1   horizontal sync, active low, registered
//  vsync       out  1   vertical sync, active low, registered
//  de          out  1   display enable, registered
//  rgb         out  24  pixel to DAC, registered
//  frame_start out  1   one-cycle pulse, registered, first cycle of each frame
// BEHAVIOUR
//  - Derived constants:
//    - H_TOTAL = sum of H_* = 800; V_TOTAL = sum of V_* = 525.
//    - H_ACT = H_SYNC+H_BACK = 144; V_ACT = V_SYNC+V_BACK = 35.
//  - Counters:
//    - cnt_h counts 0..H_TOTAL-1 and wraps.
//    - cnt_v increments only when cnt_h wraps; counts 0..V_TOTAL-1 and wraps.
//  - Reset (async, rst_n=0):
//    - cnt_h=cnt_v=0.
//    - hsync=vsync=1, de=0, rgb=0, frame_start=0.
//    - pos_valid=0, pos_x=pos_y=0.
//    - First edge after release counts from (0,0); no frame_start for that frame.
//  - Request (combinational from counters):
//    - pos_valid=1 iff H_ACT-LATENCY <= cnt_h < H_ACT+H_VALID-LATENCY and V_ACT <= cnt_v < V_ACT+V_VALID.
//    - When valid: pos_x = cnt_h+LATENCY-H_ACT, pos_y = cnt_v-V_ACT.
//    - When invalid: pos_x = pos_y = 0.
//    - Requests never cross a line boundary, because the window ends before H_TOTAL.
//  - Output regs load on each edge from the current counter (h,v):
//    - hsync <= !(h < H_SYNC)
//    - vsync <= !(v < V_SYNC)
//    - de <= (H_ACT <= h < H_ACT+H_VALID) && (V_ACT <= v < V_ACT+V_VALID)
//    - rgb <= de_comb ? pix_data : 24'h0; blanking is forced black whatever pix_data holds.
//    - frame_start <= (h==H_TOTAL-1 && v==V_TOTAL-1)
//  - Alignment: the pixel requested at counter h-LATENCY is on rgb one cycle after
//    counter==h. hsync, vsync and de carry the same 1-cycle lag.
//  - Widths: counters are 10 bits; all compares are unsigned. No subtraction result
//    goes negative, because the lookahead bound is >= 0 by parameter rule.
// STRUCTURE
//  - Shared package vga_pkg holds:
//    - 640x480@60 timing localparams (H_*, V_*, H_TOTAL, V_TOTAL).
//    - RGB888 colour constants (BLACK, WHITE).
//  - No sub-module; counters, decode and output regs sit in this file.
//  - Pixel stages instantiate beside it and share vga_clk/rst_n.
// TESTING
//  1. Reset held 10 cycles, then released.
//     -> hsync=vsync=1, de=0, rgb=0 during reset.
//     -> First hsync low appears 1 cycle after release and lasts exactly 96 cycles.
//  2. Run 2 full frames.
//     -> hsync period 800 cycles; vsync low for 2 lines (1600 cycles) every 420000 cycles.
//     -> de high 640 cycles per line on 480 lines only.
//  3. Pixel model: LATENCY=1, registered, returns {pos_x[7:0],pos_y[7:0],8'hA5}.
//     -> Line 0: first de-high rgb = 24'h0000A5; last = 24'h7F00A5 (x=639 -> 8'h7F).
//  4. LATENCY=3 with the same model.
//     -> Identical rgb sequence to scenario 3.
//     -> pos_valid rises at cnt_h=141 and falls at cnt_h=781.
//  5. Drive pix_data=24'hFFFFFF constantly.
//     -> rgb=0 whenever de=0, including porch, sync and vblank lines.
//  6. Assert rst_n low mid-line (cnt_h=400, cnt_v=200).
//     -> All outputs return to reset values asynchronously.
//     -> After release, timing restarts at (0,0).
//     -> frame_start is seen first at the end of the first complete frame (420000 cycles).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing constants and RGB888 colours
// for the VGA pixel pipeline.
package vga_pkg;

    localparam int H_SYNC  = 96;
    localparam int H_BACK  = 48;
    localparam int H_VALID = 640;
    localparam int H_FRONT = 16;
    localparam int V_SYNC  = 2;
    localparam int V_BACK  = 33;
    localparam int V_VALID = 480;
    localparam int V_FRONT = 10;

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

    localparam logic [23:0] BLACK = 24'h000000;
    localparam logic [23:0] WHITE = 24'hFFFFFF;

endpackage

// File: rtl/vga_timing_gen.sv
// Raster timing generator: counters, lookahead pixel requests and
// registered DAC outputs (hsync/vsync/de/rgb) mutually aligned.
module vga_timing_gen
    import vga_pkg::BLACK;
#(
    parameter int H_SYNC  = vga_pkg::H_SYNC,
    parameter int H_BACK  = vga_pkg::H_BACK,
    parameter int H_VALID = vga_pkg::H_VALID,
    parameter int H_FRONT = vga_pkg::H_FRONT,
    parameter int V_SYNC  = vga_pkg::V_SYNC,
    parameter int V_BACK  = vga_pkg::V_BACK,
    parameter int V_VALID = vga_pkg::V_VALID,
    parameter int V_FRONT = vga_pkg::V_FRONT,
    parameter int LATENCY = 1
) (
    input  logic        vga_clk,
    input  logic        rst_n,
    input  logic [23:0] pix_data,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic        pos_valid,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [23:0] rgb,
    output logic        frame_start
);

    localparam int HT = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int VT = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int HA = H_SYNC + H_BACK;
    localparam int VA = V_SYNC + V_BACK;

    localparam logic [9:0] HT_M1 = 10'(HT - 1);
    localparam logic [9:0] VT_M1 = 10'(VT - 1);
    localparam logic [9:0] HS10  = 10'(H_SYNC);
    localparam logic [9:0] VS10  = 10'(V_SYNC);
    localparam logic [9:0] HA10  = 10'(HA);
    localparam logic [9:0] HE10  = 10'(HA + H_VALID);
    localparam logic [9:0] VA10  = 10'(VA);
    localparam logic [9:0] VE10  = 10'(VA + V_VALID);
    localparam logic [9:0] RL10  = 10'(HA - LATENCY);
    localparam logic [9:0] RH10  = 10'(HA + H_VALID - LATENCY);
    localparam logic [9:0] LAT10 = 10'(LATENCY);

    logic [9:0]  cnt_h_q, cnt_h_d;
    logic [9:0]  cnt_v_q, cnt_v_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic [23:0] rgb_q, rgb_d;
    logic        fs_q, fs_d;
    logic        h_last, v_last, h_act, v_act, h_req;

    always_comb begin
        h_last  = (cnt_h_q == HT_M1);
        v_last  = (cnt_v_q == VT_M1);
        cnt_h_d = h_last ? 10'd0 : cnt_h_q + 10'd1;
        cnt_v_d = cnt_v_q;
        if (h_last) begin
            cnt_v_d = v_last ? 10'd0 : cnt_v_q + 10'd1;
        end
        h_act   = (cnt_h_q >= HA10) && (cnt_h_q < HE10);
        v_act   = (cnt_v_q >= VA10) && (cnt_v_q < VE10);
        // Request window leads the active window by the pixel-stage latency
        h_req   = (cnt_h_q >= RL10) && (cnt_h_q < RH10);
        hsync_d = !(cnt_h_q < HS10);
        vsync_d = !(cnt_v_q < VS10);
        de_d    = h_act && v_act;
        rgb_d   = de_d ? pix_data : BLACK;
        fs_d    = h_last && v_last;
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_h_q <= '0;
            cnt_v_q <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            rgb_q   <= BLACK;
            fs_q    <= 1'b0;
        end else begin
            cnt_h_q <= cnt_h_d;
            cnt_v_q <= cnt_v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            rgb_q   <= rgb_d;
            fs_q    <= fs_d;
        end
    end

    assign pos_valid   = h_req && v_act;
    assign pos_x       = pos_valid ? cnt_h_q + LAT10 - HA10 : 10'd0;
    assign pos_y       = pos_valid ? cnt_v_q - VA10 : 10'd0;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign rgb         = rgb_q;
    assign frame_start = fs_q;

endmodule
